// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Contents: port index type, response pipeline stage, pointer-advance helper.
// Optional feature macro used by the top: SRAM_ARB_PERF_CNT_EN.
package sram_arb_pkg;

  localparam int unsigned MAX_READ_LAT = 2;
  localparam int unsigned CNT_W        = 32;
  // Index type is sized for the largest supported requester count.
  localparam int unsigned MAX_PORTS    = 16;
  localparam int unsigned PORT_IDX_W   = $clog2(MAX_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t port;
  } rsp_pipe_t;

  // Round-robin successor of idx, wrapping num_ports-1 -> 0.
  function automatic port_idx_t next_ptr(input port_idx_t idx, input int unsigned num_ports);
    int unsigned nxt;
    nxt = 32'(idx) + 32'd1;
    return (nxt >= num_ports) ? '0 : port_idx_t'(nxt);
  endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational round-robin picker.
// Ports: req_i (request vector), ptr_i (priority pointer) ->
//        gnt_o (one-hot grant), idx_o (granted index), valid_o (any grant).
module rr_prio_sel
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_idx_t            idx_o,
  output logic                 valid_o
);

  // First pass covers ports at/after the pointer, second pass wraps to port 0.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!valid_o && req_i[p] && (p >= 32'(ptr_i))) begin
        gnt_o[p] = 1'b1;
        idx_o    = port_idx_t'(p);
        valid_o  = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!valid_o && req_i[p]) begin
        gnt_o[p] = 1'b1;
        idx_o    = port_idx_t'(p);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_PORTS requesters.
// Inputs : clk_i, rst_ni, per-port req/we/addr/wdata/wuser/be, sram_rdata_i/sram_ruser_i.
// Outputs: gnt_o (combinational one-hot), rvalid_o (READ_LAT after grant), rdata_o/ruser_o
//          (passthrough), conflict_cnt_o, sram_* request fields.
// Optional: define SRAM_ARB_PERF_CNT_EN for saturating per-port stall counters.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int unsigned NUM_PORTS  = 2,
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned USER_WIDTH = 1,
  parameter  int unsigned NUM_WORDS  = 1024,
  parameter  int unsigned READ_LAT   = 1,
  localparam int unsigned AW         = $clog2(NUM_WORDS),
  localparam int unsigned BW         = (DATA_WIDTH + 7) / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_PORTS-1:0]                  req_i,
  input  logic [NUM_PORTS-1:0]                  we_i,
  input  logic [NUM_PORTS-1:0][AW-1:0]          addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_PORTS-1:0][USER_WIDTH-1:0]  wuser_i,
  input  logic [NUM_PORTS-1:0][BW-1:0]          be_i,
  output logic [NUM_PORTS-1:0]                  gnt_o,
  output logic [NUM_PORTS-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic [USER_WIDTH-1:0]                 ruser_o,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]       conflict_cnt_o,
  output logic                                  sram_req_o,
  output logic                                  sram_we_o,
  output logic [AW-1:0]                         sram_addr_o,
  output logic [DATA_WIDTH-1:0]                 sram_wdata_o,
  output logic [USER_WIDTH-1:0]                 sram_wuser_o,
  output logic [BW-1:0]                         sram_be_o,
  input  logic [DATA_WIDTH-1:0]                 sram_rdata_i,
  input  logic [USER_WIDTH-1:0]                 sram_ruser_i
);

  // Elaboration-time parameter legality.
  if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_read_lat
    $error("sram_port_arbiter: READ_LAT must be 1 or 2");
  end
  if ((NUM_PORTS < 2) || (NUM_PORTS > MAX_PORTS)) begin : g_bad_num_ports
    $error("sram_port_arbiter: NUM_PORTS out of range");
  end

  port_idx_t ptr_q, ptr_d;
  port_idx_t gnt_idx;
  logic      gnt_any;
  rsp_pipe_t rsp_q [READ_LAT];
  rsp_pipe_t rsp_d [READ_LAT];

  rr_prio_sel #(.NUM_PORTS(NUM_PORTS)) u_sel (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_o),
    .idx_o   (gnt_idx),
    .valid_o (gnt_any)
  );

  // Pointer moves past the winner on every grant, holds when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = next_ptr(gnt_idx, NUM_PORTS);
  end

  // AND-OR field mux keyed on the one-hot grant; all zero when idle.
  always_comb begin
    sram_req_o   = gnt_any;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wuser_o = '0;
    sram_be_o    = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt_o[p]) begin
        sram_we_o    = we_i[p];
        sram_addr_o  = addr_i[p];
        sram_wdata_o = wdata_i[p];
        sram_wuser_o = wuser_i[p];
        sram_be_o    = be_i[p];
      end
    end
  end

  // Response pipeline tracks which port owns the data READ_LAT cycles later.
  always_comb begin
    rsp_d[0].valid = sram_req_o & ~sram_we_o;
    rsp_d[0].port  = gnt_idx;
    for (int unsigned s = 1; s < READ_LAT; s++) rsp_d[s] = rsp_q[s-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int unsigned s = 0; s < READ_LAT; s++) rsp_q[s] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int unsigned s = 0; s < READ_LAT; s++) rsp_q[s] <= rsp_d[s];
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = rsp_q[READ_LAT-1].valid && (rsp_q[READ_LAT-1].port == port_idx_t'(p));
    end
  end

  assign rdata_o = sram_rdata_i;
  assign ruser_o = sram_ruser_i;

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Count cycles a port requests without being granted; saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (req_i[p] && !gnt_o[p] && (cnt_q[p] != '1)) cnt_d[p] = cnt_q[p] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign conflict_cnt_o = cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: two arbiters (READ_LAT=1 and READ_LAT=2) fed identical traffic,
// each in front of its own behavioural SRAM model.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned BW = 8;

  logic clk;
  logic rst_ni;
  logic [NP-1:0]         req, we;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0][DW-1:0] wdata;
  logic [NP-1:0][0:0]    wuser;
  logic [NP-1:0][BW-1:0] be;

  logic [NP-1:0] gnt1, rvalid1, gnt2, rvalid2;
  logic [DW-1:0] rdata1, rdata2;
  logic [0:0]    ruser1, ruser2;
  logic [NP-1:0][CNT_W-1:0] cnt1, cnt2;
  logic          s1_req, s1_we, s2_req, s2_we;
  logic [AW-1:0] s1_addr, s2_addr;
  logic [DW-1:0] s1_wdata, s2_wdata, s1_rdata, s2_rdata;
  logic [0:0]    s1_wuser, s2_wuser, s1_ruser, s2_ruser;
  logic [BW-1:0] s1_be, s2_be;

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_WIDTH(1), .NUM_WORDS(1024), .READ_LAT(1)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .wuser_i(wuser), .be_i(be), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
    .ruser_o(ruser1), .conflict_cnt_o(cnt1), .sram_req_o(s1_req), .sram_we_o(s1_we),
    .sram_addr_o(s1_addr), .sram_wdata_o(s1_wdata), .sram_wuser_o(s1_wuser), .sram_be_o(s1_be),
    .sram_rdata_i(s1_rdata), .sram_ruser_i(s1_ruser));

  sram_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_WIDTH(1), .NUM_WORDS(1024), .READ_LAT(2)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .wuser_i(wuser), .be_i(be), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .ruser_o(ruser2), .conflict_cnt_o(cnt2), .sram_req_o(s2_req), .sram_we_o(s2_we),
    .sram_addr_o(s2_addr), .sram_wdata_o(s2_wdata), .sram_wuser_o(s2_wuser), .sram_be_o(s2_be),
    .sram_rdata_i(s2_rdata), .sram_ruser_i(s2_ruser));

  // SRAM model, one-cycle read latency
  logic [DW-1:0] mem1 [1024];
  logic          mu1  [1024];
  logic [DW-1:0] rd1;
  logic          ru1;
  always_ff @(posedge clk) begin
    if (s1_req) begin
      if (s1_we) begin
        for (int b = 0; b < 8; b++) if (s1_be[b]) mem1[s1_addr][b*8 +: 8] <= s1_wdata[b*8 +: 8];
        mu1[s1_addr] <= s1_wuser[0];
      end else begin
        rd1 <= mem1[s1_addr];
        ru1 <= mu1[s1_addr];
      end
    end
  end
  assign s1_rdata = rd1;
  assign s1_ruser = ru1;

  // SRAM model, two-cycle read latency (output register)
  logic [DW-1:0] mem2 [1024];
  logic          mu2  [1024];
  logic [DW-1:0] rd2a, rd2b;
  logic          ru2a, ru2b;
  always_ff @(posedge clk) begin
    if (s2_req) begin
      if (s2_we) begin
        for (int b = 0; b < 8; b++) if (s2_be[b]) mem2[s2_addr][b*8 +: 8] <= s2_wdata[b*8 +: 8];
        mu2[s2_addr] <= s2_wuser[0];
      end else begin
        rd2a <= mem2[s2_addr];
        ru2a <= mu2[s2_addr];
      end
    end
    rd2b <= rd2a;
    ru2b <= ru2a;
  end
  assign s2_rdata = rd2b;
  assign s2_ruser = ru2b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef SRAM_ARB_PERF_CNT_EN
  localparam logic [31:0] CNT_TWO = 32'd2;
  localparam logic [31:0] CNT_ONE = 32'd1;
`else
  localparam logic [31:0] CNT_TWO = 32'd0;
  localparam logic [31:0] CNT_ONE = 32'd0;
`endif

  logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0]  exp_rv1 [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
  logic [1:0]  exp_rv2 [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
  logic [63:0] exp_rd1 [4] = '{64'h0, 64'hDEAD_BEEF, 64'h1111, 64'hDEAD_BEEF};

  initial begin
    rst_ni = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; wuser = '0; be = '0;

    // 1: reset, no requests
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",      64'(gnt1),    64'h0);
    check("rst_sram_req", 64'(s1_req),  64'h0);
    check("rst_rvalid1",  64'(rvalid1), 64'h0);
    check("rst_rvalid2",  64'(rvalid2), 64'h0);
    check("rst_cnt",      64'(cnt1),    64'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // 2: P1 writes 0x10, then P0 reads it back
    next_cycle();
    req = 2'b10; we = 2'b10; addr[1] = 10'h010; wdata[1] = 64'hDEAD_BEEF; wuser[1] = 1'b1; be[1] = 8'hFF;
    #1;
    check("wr_gnt",   64'(gnt1),     64'h2);
    check("wr_req",   64'(s1_req),   64'h1);
    check("wr_we",    64'(s1_we),    64'h1);
    check("wr_addr",  64'(s1_addr),  64'h10);
    check("wr_wdata", 64'(s1_wdata), 64'hDEAD_BEEF);
    check("wr_be",    64'(s1_be),    64'hFF);

    next_cycle();
    req = 2'b01; we = 2'b00; addr[0] = 10'h010;
    #1;
    check("rd_gnt",      64'(gnt1),    64'h1);
    check("rd_we",       64'(s1_we),   64'h0);
    check("wr_norvalid", 64'(rvalid1), 64'h0);

    next_cycle();
    req = 2'b00;
    #1;
    check("idle_gnt",  64'(gnt1),    64'h0);
    check("idle_req",  64'(s1_req),  64'h0);
    check("idle_addr", 64'(s1_addr), 64'h0);
    check("rd_rvalid1", 64'(rvalid1), 64'h1);
    check("rd_rdata1",  64'(rdata1),  64'hDEAD_BEEF);
    check("rd_ruser1",  64'(ruser1),  64'h1);
    check("rd_rvalid2_early", 64'(rvalid2), 64'h0);

    next_cycle();
    #1;
    check("rd_rvalid1_done", 64'(rvalid1), 64'h0);
    check("rd_rvalid2",      64'(rvalid2), 64'h1);
    check("rd_rdata2",       64'(rdata2),  64'hDEAD_BEEF);

    // pointer is 1: lone P1 write is granted and wraps pointer to 0
    next_cycle();
    req = 2'b10; we = 2'b10; addr[1] = 10'h020; wdata[1] = 64'h1111; wuser[1] = 1'b0;
    #1;
    check("wr2_gnt", 64'(gnt1), 64'h2);

    // 3/4: both ports read back-to-back for four cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      req = 2'b11; we = 2'b00; addr[0] = 10'h010; addr[1] = 10'h020;
      #1;
      check($sformatf("rr_gnt%0d", i),     64'(gnt1),    64'(exp_gnt[i]));
      check($sformatf("rr_gnt2_%0d", i),   64'(gnt2),    64'(exp_gnt[i]));
      check($sformatf("rr_sreq2_%0d", i),  64'(s2_req),  64'h1);
      check($sformatf("rr_rv1_%0d", i),    64'(rvalid1), 64'(exp_rv1[i]));
      check($sformatf("rr_rv2_%0d", i),    64'(rvalid2), 64'(exp_rv2[i]));
      if (i > 0) check($sformatf("rr_rd1_%0d", i), 64'(rdata1), exp_rd1[i]);
    end

    next_cycle();
    req = 2'b00;
    #1;
    check("rr_rv1_tail",  64'(rvalid1), 64'h2);
    check("rr_rd1_tail",  64'(rdata1),  64'h1111);
    check("rr_rv2_tail0", 64'(rvalid2), 64'h1);
    check("rr_rd2_tail0", 64'(rdata2),  64'hDEAD_BEEF);
    check("rr_cnt0",      64'(cnt1[0]), 64'(CNT_TWO));
    check("rr_cnt1",      64'(cnt1[1]), 64'(CNT_TWO));

    next_cycle();
    #1;
    check("rr_rv1_end",   64'(rvalid1), 64'h0);
    check("rr_rv2_tail1", 64'(rvalid2), 64'h2);
    check("rr_rd2_tail1", 64'(rdata2),  64'h1111);

    // 5: reset one cycle after a read grant drops the response
    next_cycle();
    req = 2'b01; addr[0] = 10'h010;
    #1;
    check("rst_rd_gnt", 64'(gnt1), 64'h1);

    next_cycle();
    req = 2'b00;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_rv1", 64'(rvalid1), 64'h0);
    check("mid_rst_rv2", 64'(rvalid2), 64'h0);
    check("mid_rst_cnt", 64'(cnt1),    64'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    next_cycle();
    req = 2'b11; addr[0] = 10'h010; addr[1] = 10'h020;
    #1;
    check("post_rst_gnt", 64'(gnt1),    64'h1);
    check("post_rst_rv2", 64'(rvalid2), 64'h0);

    next_cycle();
    req = 2'b00;
    #1;
    check("post_rst_rv1",   64'(rvalid1), 64'h1);
    check("post_rst_rd1",   64'(rdata1),  64'hDEAD_BEEF);
    check("post_rst_cnt0",  64'(cnt1[0]), 64'h0);
    check("post_rst_cnt1",  64'(cnt1[1]), 64'(CNT_ONE));

    next_cycle();
    #1;
    check("post_rst_rv2b",  64'(rvalid2), 64'h1);

`ifdef SRAM_ARB_PERF_CNT_EN
    // 6: counter saturation from all-ones-minus-one
    force u1.cnt_q = {32'h0, 32'hFFFF_FFFE};
    #1;
    release u1.cnt_q;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      req = 2'b11;
      #1;
      check($sformatf("sat_gnt%0d", i), 64'(gnt1), (i % 2 == 0) ? 64'h2 : 64'h1);
      if (i > 0) check($sformatf("sat_cnt%0d", i), 64'(cnt1[0]), 64'hFFFF_FFFF);
    end
    next_cycle();
    req = 2'b00;
    #1;
    check("sat_cnt_final", 64'(cnt1[0]), 64'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
